mcs_gpio_irq: RTL and testbench
===============================

Name: mcs_gpio_irq

Overview:
- Parametrised GPIO peripheral for the MicroBlaze MCS I/O bus. It succeeds the fixed 8-bit gpio_o/gpio_i pair used on the mb_mcs_top board design.
- Adds input synchronisation, set/clear output access, per-bit rising/falling edge detection, sticky W1C status and a level interrupt line.
- Sits between the MCS IO bus and board pins.

Parameters:
- WIDTH, 8, number of GPIO bits in each direction (1..32).
- DEB_CYCLES, 16, debounce stability count in clk cycles (used only with GPIO_DEBOUNCE_EN; >=2).
- DEB_W, 5, debounce counter width; must satisfy 2**DEB_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock (32 MHz on board).
- reset  in  1  synchronous, active-high reset.
- io_addr_strobe  in  1  single-cycle bus access strobe.
- io_write_strobe  in  1  high with io_addr_strobe for writes, low for reads.
- io_address  in  5  byte address; bits [4:2] select the register.
- io_write_data  in  32  write data; bits [WIDTH-1:0] used.
- io_read_data  out  32  read data, zero-extended.
- io_ready  out  1  one-cycle access completion pulse.
- gpio_i  in  WIDTH  asynchronous pin inputs.
- gpio_o  out  WIDTH  registered pin outputs.
- irq  out  1  registered level interrupt.

Behaviour:
- Reset clears gpio_o, RISE_EN, FALL_EN, STATUS, irq, io_ready, io_read_data, both synchroniser stages, the prev register and debounce state. All of these read 0 on the cycle after reset is sampled high. Reset mid-access drops io_ready for that access.
- Register map, io_address[4:2]:
  - 0 OUT (rw)
  - 1 IN (ro)
  - 2 SET (wo): OUT |= data
  - 3 CLR (wo): OUT &= ~data
  - 4 RISE_EN (rw)
  - 5 FALL_EN (rw)
  - 6 STATUS (read; write-1-to-clear)
  - 7 reserved: reads 0, writes ignored.
  - Write-only registers read 0.
- Bus access:
  - Strobe sampled at edge N.
  - Write takes effect at edge N; io_ready=1 during cycle N..N+1 only.
  - Read data is registered at edge N and valid while io_ready=1; io_read_data=0 in all other cycles.
  - Back-to-back strobes on consecutive cycles are legal; each gets its own io_ready pulse.
- gpio_o is driven directly from the OUT register, so a write is visible on pins in the same cycle io_ready rises.
- Input path:
  - Two-flop synchroniser (s1, s2), then filtered value f (f=s2 without debounce), then prev register p.
  - rise = f & ~p & RISE_EN; fall = ~f & p & FALL_EN.
  - Without debounce: pin change stable before edge N appears in IN after edge N+1; STATUS bit sets at edge N+2; irq rises at edge N+3.
- STATUS:
  - STATUS[i] <= (STATUS[i] & ~w1c[i]) | rise[i] | fall[i].
  - A new edge in the same cycle as its W1C wins: the bit stays 1.
  - Clearing RISE_EN/FALL_EN does not clear existing STATUS bits.
- irq <= |STATUS, one cycle behind STATUS. It drops the cycle after the last bit clears.
- A pulse on gpio_i shorter than one clk period may be missed; no latching is required.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Per-bit counter of DEB_W bits. Counter resets to 0 whenever s2[i]==f[i].
  - Otherwise it increments; when it reaches DEB_CYCLES-1, f[i] toggles and the counter clears.
  - f therefore changes DEB_CYCLES cycles after s2 settles; glitches shorter than DEB_CYCLES cycles never reach IN or STATUS.
- Not defined: f=s2 combinationally, no counters synthesised, DEB_CYCLES/DEB_W ignored.

Test Plan:
- Reset then read OUT/IN/RISE_EN/STATUS with gpio_i=0 -> all read 0x00000000, irq=0, gpio_o=0x00, exactly one io_ready pulse per read.
- Write OUT=0xA5, SET 0x0F, CLR 0x81 -> gpio_o=0xA5, then 0xAF, then 0x2E; read OUT returns 0x0000002E.
- RISE_EN=0x01, FALL_EN=0x80, gpio_i 0x00->0x81 -> STATUS reads 0x01 (bit 7 rise not enabled), irq=1 three edges after change; gpio_i 0x81->0x00 -> STATUS=0x81.
- Write STATUS 0x01 in the same cycle bit 0 rises again -> STATUS bit 0 stays 1; then write 0x81 with no edges -> STATUS=0, irq=0 one cycle later.
- Reset asserted during a read strobe cycle -> io_ready stays 0, all registers 0 next cycle; read of address 7 returns 0 and a write to it has no effect.
- With GPIO_DEBOUNCE_EN, DEB_CYCLES=16: 10-cycle pulse on gpio_i[2] -> IN and STATUS unchanged; 40-cycle high -> IN[2]=1 after 18 cycles (2 sync + 16), STATUS[2]=1 if RISE_EN[2].

Source files
------------

// File: rtl/mcs_gpio_irq.sv
// GPIO peripheral for the MicroBlaze MCS I/O bus: synchronised inputs, set/clear outputs,
// per-bit edge detection into sticky W1C status and a level irq. Optional input filter: GPIO_DEBOUNCE_EN.
module mcs_gpio_irq #(
   parameter int WIDTH      = 8,
   parameter int DEB_CYCLES = 16,
   parameter int DEB_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_addr_strobe,
   input  logic             io_write_strobe,
   input  logic [4:0]       io_address,
   input  logic [31:0]      io_write_data,
   output logic [31:0]      io_read_data,
   output logic             io_ready,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_OUT    = 3'd0,
      REG_IN     = 3'd1,
      REG_SET    = 3'd2,
      REG_CLR    = 3'd3,
      REG_RISE   = 3'd4,
      REG_FALL   = 3'd5,
      REG_STATUS = 3'd6,
      REG_RSVD   = 3'd7
   } reg_sel_t;

   reg_sel_t         sel;
   logic             wr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] out_reg, rise_en, fall_en, status;
   logic [WIDTH-1:0] s1, s2, f, p;
   logic [WIDTH-1:0] rise, fall, w1c;
   logic [31:0]      rd_mux;
   logic             unused_bits;

   assign sel         = reg_sel_t'(io_address[4:2]);
   assign wr          = io_addr_strobe & io_write_strobe;
   assign wdata       = io_write_data[WIDTH-1:0];
   assign gpio_o      = out_reg;
   assign unused_bits = ^{io_address[1:0], io_write_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         p  <= '0;
      end else begin
         s1 <= gpio_i;
         s2 <= s1;
         p  <= f;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   // f only follows s2 once s2 has disagreed with it for DEB_CYCLES consecutive cycles.
   logic [DEB_W-1:0] deb_cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         f <= '0;
         for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == f[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
               f[i]       <= ~f[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   logic [DEB_W-1:0] unused_deb;
   assign unused_deb = DEB_W'(DEB_CYCLES);
   assign f          = s2;
`endif

   assign rise = f & ~p & rise_en;
   assign fall = ~f & p & fall_en;
   assign w1c  = (wr && sel == REG_STATUS) ? wdata : '0;

   // Write-only and reserved addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      case (sel)
         REG_OUT:    rd_mux[WIDTH-1:0] = out_reg;
         REG_IN:     rd_mux[WIDTH-1:0] = f;
         REG_RISE:   rd_mux[WIDTH-1:0] = rise_en;
         REG_FALL:   rd_mux[WIDTH-1:0] = fall_en;
         REG_STATUS: rd_mux[WIDTH-1:0] = status;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_reg      <= '0;
         rise_en      <= '0;
         fall_en      <= '0;
         status       <= '0;
         irq          <= 1'b0;
         io_ready     <= 1'b0;
         io_read_data <= '0;
      end else begin
         if (wr) begin
            case (sel)
               REG_OUT:  out_reg <= wdata;
               REG_SET:  out_reg <= out_reg | wdata;
               REG_CLR:  out_reg <= out_reg & ~wdata;
               REG_RISE: rise_en <= wdata;
               REG_FALL: fall_en <= wdata;
               default:  ;
            endcase
         end
         // A fresh edge outranks a same-cycle clear.
         status       <= (status & ~w1c) | rise | fall;
         irq          <= |status;
         io_ready     <= io_addr_strobe;
         io_read_data <= (io_addr_strobe && !io_write_strobe) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_mcs_gpio_irq.sv
// Directed bench for mcs_gpio_irq: bus access, set/clear, edge status, W1C race, reset and reserved map.
module tb_mcs_gpio_irq;

`ifdef GPIO_DEBOUNCE_EN
   localparam int LAT = 16;
`else
   localparam int LAT = 0;
`endif

   logic        clk;
   logic        reset;
   logic        io_addr_strobe;
   logic        io_write_strobe;
   logic [4:0]  io_address;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;
   logic        io_ready;
   logic [7:0]  gpio_i;
   logic [7:0]  gpio_o;
   logic        irq;

   int total = 0;
   int bad   = 0;
   logic [31:0] rdata;

   mcs_gpio_irq #(.WIDTH(8), .DEB_CYCLES(16), .DEB_W(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .io_addr_strobe (io_addr_strobe),
      .io_write_strobe(io_write_strobe),
      .io_address     (io_address),
      .io_write_data  (io_write_data),
      .io_read_data   (io_read_data),
      .io_ready       (io_ready),
      .gpio_i         (gpio_i),
      .gpio_o         (gpio_o),
      .irq            (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // One strobe; checks the io_ready pulse shape and idle read data.
   task automatic applyStimulus(input logic wr, input logic [2:0] sel, input logic [31:0] data,
                                output logic [31:0] rd);
      @(negedge clk);
      io_addr_strobe  = 1'b1;
      io_write_strobe = wr;
      io_address      = {sel, 2'b00};
      io_write_data   = data;
      @(posedge clk); #1;
      io_addr_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      checkOutput("ready_pulse", {31'd0, io_ready}, 32'd1);
      rd = io_read_data;
      @(posedge clk); #1;
      checkOutput("ready_drop", {31'd0, io_ready}, 32'd0);
      checkOutput("rdata_idle", io_read_data, 32'd0);
   endtask

   initial begin
      reset = 1'b1; io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
      io_address = '0; io_write_data = '0; gpio_i = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", {31'd0, io_ready}, 32'd0);
      checkOutput("rst_gpio_o", {24'd0, gpio_o}, 32'd0);
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      checkOutput("rst_rdata", io_read_data, 32'd0);
      @(negedge clk); reset = 1'b0;

      applyStimulus(1'b0, 3'd0, 32'd0, rdata); checkOutput("rd_out0", rdata, 32'h0);
      applyStimulus(1'b0, 3'd1, 32'd0, rdata); checkOutput("rd_in0", rdata, 32'h0);
      applyStimulus(1'b0, 3'd4, 32'd0, rdata); checkOutput("rd_rise0", rdata, 32'h0);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("rd_stat0", rdata, 32'h0);

      applyStimulus(1'b1, 3'd0, 32'hA5, rdata); checkOutput("out_wr", {24'd0, gpio_o}, 32'hA5);
      applyStimulus(1'b1, 3'd2, 32'h0F, rdata); checkOutput("out_set", {24'd0, gpio_o}, 32'hAF);
      applyStimulus(1'b1, 3'd3, 32'h81, rdata); checkOutput("out_clr", {24'd0, gpio_o}, 32'h2E);
      applyStimulus(1'b0, 3'd0, 32'd0, rdata); checkOutput("rd_out", rdata, 32'h2E);

      applyStimulus(1'b1, 3'd4, 32'h01, rdata);
      applyStimulus(1'b1, 3'd5, 32'h80, rdata);
      // Pin change before edge N: status at N+2, irq at N+3.
      @(negedge clk); gpio_i = 8'h81;
      @(posedge clk); @(posedge clk);
      repeat (LAT) @(posedge clk);
      @(posedge clk); #1;
      checkOutput("irq_n2", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      checkOutput("irq_n3", {31'd0, irq}, 32'd1);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("stat_rise", rdata, 32'h01);
      applyStimulus(1'b0, 3'd1, 32'd0, rdata); checkOutput("rd_in81", rdata, 32'h81);
      @(negedge clk); gpio_i = 8'h00;
      repeat (4 + LAT) @(posedge clk);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("stat_fall", rdata, 32'h81);

      // W1C of bit 0 lands on the same edge bit 0 re-rises.
      @(negedge clk); gpio_i = 8'h01;
      @(posedge clk); @(posedge clk);
      repeat (LAT) @(posedge clk);
      applyStimulus(1'b1, 3'd6, 32'h01, rdata);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("stat_race", rdata, 32'h81);
      @(negedge clk);
      io_addr_strobe = 1'b1; io_write_strobe = 1'b1; io_address = {3'd6, 2'b00}; io_write_data = 32'h81;
      @(posedge clk); #1;
      io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
      checkOutput("irq_hold", {31'd0, irq}, 32'd1);
      @(posedge clk); #1;
      checkOutput("irq_drop", {31'd0, irq}, 32'd0);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("stat_clr", rdata, 32'h0);

      // Reset on the strobe edge swallows the access.
      @(negedge clk);
      io_addr_strobe = 1'b1; io_write_strobe = 1'b0; io_address = {3'd0, 2'b00}; reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_mid_ready", {31'd0, io_ready}, 32'd0);
      checkOutput("rst_mid_rdata", io_read_data, 32'd0);
      checkOutput("rst_mid_gpio", {24'd0, gpio_o}, 32'd0);
      @(negedge clk); io_addr_strobe = 1'b0; reset = 1'b0;
      applyStimulus(1'b0, 3'd5, 32'd0, rdata); checkOutput("rst_fall_en", rdata, 32'h0);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("rst_stat", rdata, 32'h0);

      applyStimulus(1'b1, 3'd7, 32'hFF, rdata);
      applyStimulus(1'b0, 3'd7, 32'd0, rdata); checkOutput("rd_rsvd", rdata, 32'h0);
      applyStimulus(1'b0, 3'd0, 32'd0, rdata); checkOutput("rsvd_noeff", rdata, 32'h0);
      applyStimulus(1'b0, 3'd2, 32'd0, rdata); checkOutput("rd_set_wo", rdata, 32'h0);

      // Back-to-back strobes: write then read, each with its own ready.
      @(negedge clk);
      io_addr_strobe = 1'b1; io_write_strobe = 1'b1; io_address = {3'd0, 2'b00}; io_write_data = 32'h3C;
      @(posedge clk); #1;
      checkOutput("b2b_ready1", {31'd0, io_ready}, 32'd1);
      io_write_strobe = 1'b0;
      @(posedge clk); #1;
      io_addr_strobe = 1'b0;
      checkOutput("b2b_ready2", {31'd0, io_ready}, 32'd1);
      checkOutput("b2b_rdata", io_read_data, 32'h3C);
      @(posedge clk); #1;
      checkOutput("b2b_idle", {31'd0, io_ready}, 32'd0);

`ifdef GPIO_DEBOUNCE_EN
      repeat (LAT + 4) @(posedge clk);
      applyStimulus(1'b1, 3'd4, 32'h04, rdata);
      @(negedge clk); gpio_i = 8'h05;
      repeat (10) @(negedge clk);
      gpio_i = 8'h01;
      repeat (30) @(posedge clk);
      applyStimulus(1'b0, 3'd1, 32'd0, rdata); checkOutput("deb_glitch_in", rdata, 32'h01);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("deb_glitch_st", rdata, 32'h00);
      @(negedge clk); gpio_i = 8'h05;
      @(posedge clk);
      repeat (16) @(posedge clk);
      applyStimulus(1'b0, 3'd1, 32'd0, rdata); checkOutput("deb_in_early", rdata, 32'h01);
      applyStimulus(1'b0, 3'd1, 32'd0, rdata); checkOutput("deb_in_late", rdata, 32'h05);
      applyStimulus(1'b0, 3'd6, 32'd0, rdata); checkOutput("deb_stat", rdata, 32'h04);
      repeat (20) @(posedge clk);
      @(negedge clk); gpio_i = 8'h01;
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
